// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external combinational ALU between two requesters. Requests are
//   arbitrated round-robin; the winner's opcode and operands are latched into
//   registers that drive the ALU, the ALU result and flags are captured one
//   cycle later and held on the response port until the owner accepts them.
//   A response handshake and a new grant may happen in the same cycle, which
//   gives a peak rate of one operation every two cycles.
//
// Optional feature:
//   Define ALU_ARBITER_STATS_EN to add the gnt_cnt output: one saturating
//   accept counter per requester (slice i = requester i), cleared by rst.
//
// Ports:
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   req_valid     : [1:0] request valid, bit i = requester i
//   req_ready     : [1:0] request accepted this cycle (one-hot or zero)
//   req_opcode    : [5:0] opcode, requester i in [3i+2:3i]
//   req_op_0/1    : [2*DATA_WIDTH-1:0] operands, requester i in slice i
//   rsp_valid     : [1:0] result valid for requester i (at most one bit)
//   rsp_ready     : [1:0] requester i accepts the result
//   rsp_data      : registered ALU result, shared by both requesters
//   rsp_zero      : registered ALU ZERO flag
//   rsp_negative  : registered ALU NEGATIVE flag
//   alu_opcode    : [2:0] to ALU opcode
//   alu_op_0/1    : [DATA_WIDTH-1:0] to ALU operands
//   alu_out       : [DATA_WIDTH-1:0] from ALU result
//   alu_zero      : from ALU ZERO
//   alu_negative  : from ALU NEGATIVE
//   gnt_cnt       : [2*CNT_WIDTH-1:0] grant counters (ALU_ARBITER_STATS_EN only)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [5:0]              req_opcode,
    input  logic [2*DATA_WIDTH-1:0] req_op_0,
    input  logic [2*DATA_WIDTH-1:0] req_op_1,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_zero,
    output logic                    rsp_negative,
    output logic [2:0]              alu_opcode,
    output logic [DATA_WIDTH-1:0]   alu_op_0,
    output logic [DATA_WIDTH-1:0]   alu_op_1,
    input  logic [DATA_WIDTH-1:0]   alu_out,
    input  logic                    alu_zero,
    input  logic                    alu_negative
`ifdef ALU_ARBITER_STATS_EN
   ,output logic [2*CNT_WIDTH-1:0]  gnt_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   rr_ptr;
    logic   owner;

    logic   can_grant;
    logic   grant_any;
    logic   grant_idx;
    logic   accept;

    // A new grant is possible when idle, or in RESP in the very cycle the
    // owner takes its result, so the next op can start without a bubble.
    always_comb begin
        can_grant = 1'b0;
        if (state == IDLE) begin
            can_grant = 1'b1;
        end else if (state == RESP) begin
            can_grant = rsp_ready[owner];
        end
    end

    // Choose the winner: a lone requester always wins, a tie goes to the
    // round-robin pointer, which always points away from the last winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        case (req_valid)
            2'b01: begin
                grant_any = 1'b1;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant_any = 1'b1;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_any = 1'b1;
                grant_idx = rr_ptr;
            end
            default: begin
                grant_any = 1'b0;
                grant_idx = rr_ptr;
            end
        endcase
    end

    assign accept    = can_grant & grant_any;
    assign req_ready = accept ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

    // The response is presented only to the owner; the other bit stays low.
    assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    // Next-state logic: EXEC always lasts exactly one cycle; RESP leaves only
    // on the owner's handshake, straight into EXEC if a new op was granted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready[owner]) begin
                    state_next = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, arbitration pointer and datapath registers. The ALU inputs only
    // change on an accept, so they hold steady while idle or waiting on a
    // slow requester. The ALU result is sampled at the end of EXEC, once
    // the latched operands have had a full cycle to settle through the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            owner        <= 1'b0;
            alu_opcode   <= '0;
            alu_op_0     <= '0;
            alu_op_1     <= '0;
            rsp_data     <= '0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner      <= grant_idx;
                rr_ptr     <= ~grant_idx;
                alu_opcode <= grant_idx ? req_opcode[5:3] : req_opcode[2:0];
                alu_op_0   <= grant_idx ? req_op_0[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : req_op_0[DATA_WIDTH-1:0];
                alu_op_1   <= grant_idx ? req_op_1[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : req_op_1[DATA_WIDTH-1:0];
            end
            if (state == EXEC) begin
                rsp_data     <= alu_out;
                rsp_zero     <= alu_zero;
                rsp_negative <= alu_negative;
            end
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [2];

    // One counter per requester, bumped on each of its accepts and pinned
    // at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept && (grant_idx == 1'(i)) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign gnt_cnt = {cnt[1], cnt[0]};
`else
    // CNT_WIDTH only sizes the counters; keep it referenced when they are absent.
    logic [CNT_WIDTH-1:0] unused_cnt_width;
    assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter. A small behavioural ALU closes the
//   loop on the alu_* ports. Expected responses are pushed onto a queue when
//   a request is driven and popped when the arbiter presents a response.
//   Define ALU_ARBITER_STATS_EN to also exercise the saturating grant
//   counters (instantiated with a 2-bit counter width).
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int DW    = 32;
    localparam int CNT_W = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [5:0]      req_opcode;
    logic [2*DW-1:0] req_op_0;
    logic [2*DW-1:0] req_op_1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_zero;
    logic            rsp_negative;
    logic [2:0]      alu_opcode;
    logic [DW-1:0]   alu_op_0;
    logic [DW-1:0]   alu_op_1;
    logic [DW-1:0]   alu_out;
    logic            alu_zero;
    logic            alu_negative;
`ifdef ALU_ARBITER_STATS_EN
    logic [2*CNT_W-1:0] gnt_cnt;
`endif

    typedef struct packed {
        logic          who;
        logic [DW-1:0] data;
        logic          zero;
        logic          negative;
    } exp_t;

    exp_t sb_q[$];
    int   check_count;
    int   pass_count;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_op_0     (req_op_0),
        .req_op_1     (req_op_1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .alu_opcode   (alu_opcode),
        .alu_op_0     (alu_op_0),
        .alu_op_1     (alu_op_1),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative)
`ifdef ALU_ARBITER_STATS_EN
       ,.gnt_cnt      (gnt_cnt)
`endif
    );

    // Behavioural stand-in for the shared ALU
    always_comb begin
        alu_out = '0;
        case (alu_opcode)
            OP_ADD:  alu_out = alu_op_0 + alu_op_1;
            OP_SUB:  alu_out = alu_op_0 - alu_op_1;
            OP_AND:  alu_out = alu_op_0 & alu_op_1;
            OP_OR:   alu_out = alu_op_0 | alu_op_1;
            OP_XOR:  alu_out = alu_op_0 ^ alu_op_1;
            OP_SLL:  alu_out = alu_op_0 << alu_op_1[4:0];
            OP_SRL:  alu_out = alu_op_0 >> alu_op_1[4:0];
            default: alu_out = DW'($signed(alu_op_0) >>> alu_op_1[4:0]);
        endcase
        alu_zero     = (alu_out == '0);
        alu_negative = alu_out[DW-1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [2:0] c0, input logic [DW-1:0] a0,
                                 input logic [DW-1:0] b0,
                                 input logic [2:0] c1, input logic [DW-1:0] a1,
                                 input logic [DW-1:0] b1);
        req_valid  = valid;
        req_opcode = {c1, c0};
        req_op_0   = {a1, a0};
        req_op_1   = {b1, b0};
        #1;
    endtask

    task automatic pushExpect(input logic who, input logic [DW-1:0] data,
                              input logic z, input logic n);
        exp_t e;
        e.who      = who;
        e.data     = data;
        e.zero     = z;
        e.negative = n;
        sb_q.push_back(e);
    endtask

    task automatic checkResponse(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'(rsp_valid), 64'hDEAD);
        end else begin
            e = sb_q.pop_front();
            checkOutput({tag, "_valid"}, 64'(rsp_valid), e.who ? 64'h2 : 64'h1);
            checkOutput({tag, "_data"}, 64'(rsp_data), 64'(e.data));
            checkOutput({tag, "_zero"}, 64'(rsp_zero), 64'(e.zero));
            checkOutput({tag, "_neg"}, 64'(rsp_negative), 64'(e.negative));
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        rsp_ready = 2'b00;
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'h0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'h0);
        checkOutput({tag, "_rsp_zero"}, 64'(rsp_zero), 64'h0);
        checkOutput({tag, "_rsp_neg"}, 64'(rsp_negative), 64'h0);
        checkOutput({tag, "_alu_opcode"}, 64'(alu_opcode), 64'h0);
        checkOutput({tag, "_alu_op_0"}, 64'(alu_op_0), 64'h0);
        checkOutput({tag, "_alu_op_1"}, 64'(alu_op_1), 64'h0);
    endtask

    // Directed sequence covering latency, tie-break, round-robin, hold,
    // reset in flight and the optional counters.
    initial begin
        check_count = 0;
        pass_count  = 0;
        rst         = 1'b1;
        rsp_ready   = 2'b00;
        req_valid   = 2'b00;
        req_opcode  = '0;
        req_op_0    = '0;
        req_op_1    = '0;

        // Reset values
        doReset();
        checkAllZero("reset");

        // Single request: ADD 15+10, latency two cycles
        applyStimulus(2'b01, OP_ADD, 32'd15, 32'd10, OP_ADD, 0, 0);
        checkOutput("t1_ready_T", 64'(req_ready), 64'h1);
        pushExpect(1'b0, 32'd25, 1'b0, 1'b0);
        tick();
        checkOutput("t1_ready_T1", 64'(req_ready), 64'h0);
        checkOutput("t1_alu_op_0", 64'(alu_op_0), 64'd15);
        checkOutput("t1_rsp_valid_T1", 64'(rsp_valid), 64'h0);
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        tick();
        checkResponse("t1_rsp");
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        #1;
        checkOutput("t1_rsp_clear", 64'(rsp_valid), 64'h0);

        // Tie after reset: requester 0 first, then 1
        doReset();
        applyStimulus(2'b11, OP_SUB, 32'd20, 32'd5, OP_SUB, 32'd5, 32'd20);
        checkOutput("t2_tie_ready", 64'(req_ready), 64'h1);
        pushExpect(1'b0, 32'd15, 1'b0, 1'b0);
        tick();
        applyStimulus(2'b10, OP_SUB, 32'd20, 32'd5, OP_SUB, 32'd5, 32'd20);
        tick();
        checkResponse("t2_rsp0");
        rsp_ready = 2'b01;
        #1;
        checkOutput("t2_ready_req1", 64'(req_ready), 64'h2);
        pushExpect(1'b1, 32'hFFFF_FFF1, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        rsp_ready = 2'b00;
        tick();
        checkResponse("t2_rsp1");
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        #1;

        // Both held valid: alternating grants, back-to-back in RESP
        rsp_ready = 2'b11;
        applyStimulus(2'b11, OP_ADD, 32'd1, 32'd2, OP_ADD, 32'd100, 32'd200);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("t3_grant%0d", k), 64'(req_ready),
                        (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k % 2 == 0) pushExpect(1'b0, 32'd3, 1'b0, 1'b0);
            else            pushExpect(1'b1, 32'd300, 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("t3_exec_ready%0d", k), 64'(req_ready), 64'h0);
            tick();
            checkResponse($sformatf("t3_rsp%0d", k));
        end
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        checkOutput("t3_no_grant", 64'(req_ready), 64'h0);
        tick();
        checkOutput("t3_idle", 64'(rsp_valid), 64'h0);
        rsp_ready = 2'b00;

        // Slow owner: response held, other requester blocked
        applyStimulus(2'b10, OP_XOR, 32'hAA, 32'hAA, OP_SRA, 32'hFFFF_FF88, 32'd3);
        checkOutput("t4_ready", 64'(req_ready), 64'h2);
        pushExpect(1'b1, 32'hFFFF_FFF1, 1'b0, 1'b1);
        tick();
        applyStimulus(2'b01, OP_XOR, 32'hAA, 32'hAA, OP_SRA, 32'hFFFF_FF88, 32'd3);
        checkOutput("t4_exec_ready", 64'(req_ready), 64'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            rsp_ready = (k >= 3) ? 2'b01 : 2'b00;
            #1;
            checkOutput($sformatf("t4_hold_valid%0d", k), 64'(rsp_valid), 64'h2);
            checkOutput($sformatf("t4_hold_data%0d", k), 64'(rsp_data), 64'hFFFF_FFF1);
            checkOutput($sformatf("t4_hold_ready%0d", k), 64'(req_ready), 64'h0);
            tick();
        end
        checkResponse("t4_rsp");
        rsp_ready = 2'b10;
        #1;
        checkOutput("t4_handoff_ready", 64'(req_ready), 64'h1);
        pushExpect(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        rsp_ready = 2'b00;
        tick();
        checkResponse("t5_xor");
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Reset during EXEC discards the op; pointer returns to requester 0
        applyStimulus(2'b01, OP_ADD, 32'd7, 32'd8, OP_ADD, 0, 0);
        tick();
        rst = 1'b1;
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        tick();
        checkAllZero("t5_midreset");
        rst = 1'b0;
        applyStimulus(2'b11, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd2, 32'd2);
        checkOutput("t5_post_reset_grant", 64'(req_ready), 64'h1);
        pushExpect(1'b0, 32'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
        tick();
        checkResponse("t5_post_rsp");
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

`ifdef ALU_ARBITER_STATS_EN
        // Saturating grant counter for requester 0
        doReset();
        checkOutput("t6_cnt_reset", 64'(gnt_cnt), 64'h0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b01, OP_OR, 32'h10, 32'h01, OP_ADD, 0, 0);
            pushExpect(1'b0, 32'h11, 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("t6_cnt%0d", k), 64'(gnt_cnt[1:0]),
                        (k < 3) ? 64'(k + 1) : 64'd3);
            checkOutput($sformatf("t6_cnt1_%0d", k), 64'(gnt_cnt[3:2]), 64'd0);
            applyStimulus(2'b00, OP_ADD, 0, 0, OP_ADD, 0, 0);
            tick();
            checkResponse($sformatf("t6_rsp%0d", k));
            rsp_ready = 2'b01;
            tick();
            rsp_ready = 2'b00;
        end
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
